// File: rtl/marker_scan_ctrl.sv
`timescale 1ns/1ps
// marker_scan_ctrl: sequences one per-row marker detector and collects the best
// (lowest nt_probability) candidate of each active line into a show-ahead FIFO.
module marker_scan_ctrl #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned PROB_MAX = 50,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        det_done_in,
    input  logic [10:0] det_coord_in,
    input  logic [10:0] det_prob_in,
    output logic        det_rst_out,
    output logic        cand_valid_out,
    input  logic        cand_ready_in,
    output logic [10:0] cand_x_out,
    output logic [9:0]  cand_y_out,
    output logic [10:0] cand_prob_out,
    output logic [2:0]  fifo_count_out,
    output logic [7:0]  drop_count_out
);

    localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] HActive  = 11'(H_ACTIVE);
    localparam logic [9:0]  VActive  = 10'(V_ACTIVE);
    localparam logic [10:0] ProbMax  = 11'(PROB_MAX);
    localparam logic [2:0]  DepthC   = 3'(DEPTH);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1
    } state_e;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [10:0] p;
    } entry_t;

    state_e            state_q, state_d;
    logic              best_valid_q, best_valid_d;
    logic [10:0]       best_coord_q, best_coord_d;
    logic [10:0]       best_prob_q, best_prob_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic [7:0]        drop_q, drop_d;
    entry_t            mem_q [DEPTH];
    entry_t            head;
    entry_t            push_entry;

    logic fs, active, capture, commit, push_req, push_ok, pop;

    assign fs      = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign active  = (hcount_in < HActive) && (vcount_in < VActive);
    assign capture = (state_q == StScan) && active && det_done_in && (det_prob_in <= ProbMax);
    assign commit  = (state_q == StScan) && (hcount_in == HActive) && (vcount_in < VActive);

    assign push_req = commit && best_valid_q;
    assign pop      = cand_valid_out && cand_ready_in;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok  = push_req && ((count_q < DepthC) || pop);

    assign push_entry = '{x: best_coord_q, y: vcount_in, p: best_prob_q};
    assign head       = mem_q[rd_ptr_q];

    // Detector held in reset while idle, through blanking and at every line start.
    assign det_rst_out    = (state_q == StIdle) || !active || (hcount_in == 11'd0);
    assign cand_valid_out = (count_q != 3'd0);
    assign cand_x_out     = cand_valid_out ? head.x : 11'd0;
    assign cand_y_out     = cand_valid_out ? head.y : 10'd0;
    assign cand_prob_out  = cand_valid_out ? head.p : 11'd0;
    assign fifo_count_out = count_q;
    assign drop_count_out = drop_q;

    // Scan enable is only looked at on frame start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fs && enable_in)  state_d = StScan;
            StScan:  if (fs && !enable_in) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Best-candidate tracking, FIFO pointer/occupancy and drop counter updates.
    always_comb begin
        best_valid_d = best_valid_q;
        best_coord_d = best_coord_q;
        best_prob_d  = best_prob_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_d       = drop_q;

        // Strict less-than: a tie keeps the earlier candidate.
        if (capture && (!best_valid_q || (det_prob_in < best_prob_q))) begin
            best_valid_d = 1'b1;
            best_coord_d = det_coord_in;
            best_prob_d  = det_prob_in;
        end
        if (commit) begin
            best_valid_d = 1'b0;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        if (push_req && !push_ok && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            best_valid_q <= 1'b0;
            best_coord_q <= 11'd0;
            best_prob_q  <= 11'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= 3'd0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            best_valid_q <= best_valid_d;
            best_coord_q <= best_coord_d;
            best_prob_q  <= best_prob_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates the outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in && push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_marker_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for marker_scan_ctrl: sparse line timelines, a queue-based reference model
// checked every cycle, plus literal checks on the popped candidate stream.
module tb_marker_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        enable_in = 1'b0;
    logic [10:0] hcount_in = 11'd5;
    logic [9:0]  vcount_in = 10'd5;
    logic        det_done_in = 1'b0;
    logic [10:0] det_coord_in = 11'd0;
    logic [10:0] det_prob_in = 11'd0;
    logic        det_rst_out;
    logic        cand_valid_out;
    logic        cand_ready_in = 1'b0;
    logic [10:0] cand_x_out;
    logic [9:0]  cand_y_out;
    logic [10:0] cand_prob_out;
    logic [2:0]  fifo_count_out;
    logic [7:0]  drop_count_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;
    bit rdy      = 1'b0;

    typedef struct { int x; int y; int p; } ent_t;
    ent_t mq[$];
    ent_t dut_pops[$];
    bit   m_en;
    bit   m_bv;
    int   m_bc, m_bp, m_drop;

    marker_scan_ctrl dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .enable_in      (enable_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .det_done_in    (det_done_in),
        .det_coord_in   (det_coord_in),
        .det_prob_in    (det_prob_in),
        .det_rst_out    (det_rst_out),
        .cand_valid_out (cand_valid_out),
        .cand_ready_in  (cand_ready_in),
        .cand_x_out     (cand_x_out),
        .cand_y_out     (cand_y_out),
        .cand_prob_out  (cand_prob_out),
        .fifo_count_out (fifo_count_out),
        .drop_count_out (drop_count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pop_field(input int idx, input int which);
        if (idx >= dut_pops.size()) return -1;
        case (which)
            0:       return dut_pops[idx].x;
            1:       return dut_pops[idx].y;
            default: return dut_pops[idx].p;
        endcase
    endfunction

    // Reference model: one line's best candidate, a DEPTH-4 queue, a saturating drop count.
    task automatic model_step();
        int   h, v;
        bit   act, pop, acc;
        ent_t e;
        if (rst_in) begin
            m_en = 0; m_bv = 0; m_bc = 0; m_bp = 0; m_drop = 0;
            mq.delete();
            return;
        end
        h   = int'(hcount_in);
        v   = int'(vcount_in);
        act = (h < 1024) && (v < 768);
        pop = (mq.size() > 0) && cand_ready_in;
        acc = 0;
        if (m_en && act && det_done_in && det_prob_in <= 50 && (!m_bv || det_prob_in < m_bp)) begin
            m_bv = 1; m_bc = int'(det_coord_in); m_bp = int'(det_prob_in);
        end
        if (m_en && h == 1024 && v < 768) begin
            if (m_bv) begin
                if (mq.size() < 4 || pop) begin
                    acc = 1;
                    e.x = m_bc; e.y = v; e.p = m_bp;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            m_bv = 0;
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(e);
        if (h == 0 && v == 0) m_en = enable_in;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        bit   act;
        ent_t e;
        forever begin
            @(negedge clk);
            if (checking) begin
                act = (hcount_in < 11'd1024) && (vcount_in < 10'd768);
                chk("count", int'(fifo_count_out), mq.size());
                chk("valid", int'(cand_valid_out), int'(mq.size() > 0));
                chk("drop", int'(drop_count_out), m_drop);
                chk("det_rst", int'(det_rst_out), int'(!m_en || !act || hcount_in == 11'd0));
                if (mq.size() > 0) begin
                    e = mq[0];
                    chk("head_x", int'(cand_x_out), e.x);
                    chk("head_y", int'(cand_y_out), e.y);
                    chk("head_p", int'(cand_prob_out), e.p);
                end else begin
                    chk("head_zero", int'(cand_x_out) + int'(cand_y_out) + int'(cand_prob_out), 0);
                end
                if (cand_valid_out && cand_ready_in && !rst_in) begin
                    e.x = int'(cand_x_out); e.y = int'(cand_y_out); e.p = int'(cand_prob_out);
                    dut_pops.push_back(e);
                end
            end
        end
    end

    task automatic drive(input int h, input int v, input bit done, input int c, input int p);
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        det_done_in  = done;
        det_coord_in = 11'(c);
        det_prob_in  = 11'(p);
        cand_ready_in = rdy;
        @(posedge clk);
        #1;
    endtask

    // Sparse line: start, up to 3 detector pulses, end of active, commit, blanking.
    task automatic line(input int v, input int n, input int eh[3], input int ec[3],
                        input int ep[3], input bit rc);
        drive(0, v, 0, 0, 0);
        drive(1, v, 0, 0, 0);
        for (int i = 0; i < n; i++) drive(eh[i], v, 1, ec[i], ep[i]);
        drive(1023, v, 0, 0, 0);
        if (rc) begin
            hcount_in = 11'd1024; vcount_in = 10'(v); det_done_in = 0;
            cand_ready_in = 1'b1;
            @(posedge clk);
            #1;
        end else begin
            drive(1024, v, 0, 0, 0);
        end
        drive(1025, v, 0, 0, 0);
        drive(1200, v, 0, 0, 0);
    endtask

    task automatic empty_line(input int v);
        line(v, 0, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, 1'b0);
    endtask

    task automatic one_evt(input int v, input int c, input int p);
        line(v, 1, '{300, 0, 0}, '{c, 0, 0}, '{p, 0, 0}, 1'b0);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(10, 768, 0, 0, 0);
    endtask

    initial begin
        // Reset
        drive(5, 5, 0, 0, 0);
        drive(5, 5, 0, 0, 0);
        checking = 1'b1;
        chk("rst_valid", int'(cand_valid_out), 0);
        chk("rst_count", int'(fifo_count_out), 0);
        chk("rst_drop", int'(drop_count_out), 0);
        chk("rst_det_rst", int'(det_rst_out), 1);
        rst_in = 1'b0;

        // Frame A: best-of-line, probability limit and tie rule
        enable_in = 1'b1; rdy = 1'b1;
        empty_line(0);
        empty_line(4);
        drive(0, 4, 0, 0, 0);
        drive(400, 4, 0, 0, 0);
        chk("scan_det_rst_mid", int'(det_rst_out), 0);
        line(5, 2, '{300, 600, 0}, '{280, 560, 0}, '{12, 7, 0}, 1'b0);
        empty_line(6);
        line(9, 3, '{300, 500, 800}, '{100, 400, 700}, '{60, 20, 20}, 1'b0);
        blank(4);
        chk("A_npops", dut_pops.size(), 2);
        chk("A0_x", pop_field(0, 0), 560);
        chk("A0_y", pop_field(0, 1), 5);
        chk("A0_p", pop_field(0, 2), 7);
        chk("A1_x", pop_field(1, 0), 400);
        chk("A1_y", pop_field(1, 1), 9);
        chk("A1_p", pop_field(1, 2), 20);

        // Frame B: fill, overflow drops, full+pop+push, ordered drain
        dut_pops.delete();
        rdy = 1'b0;
        empty_line(0);
        for (int v = 1; v <= 6; v++) one_evt(v, 10 * v, v);
        chk("B_full_count", int'(fifo_count_out), 4);
        chk("B_drop2", int'(drop_count_out), 2);
        line(10, 1, '{300, 0, 0}, '{100, 0, 0}, '{10, 0, 0}, 1'b1);
        chk("B_still_full", int'(fifo_count_out), 4);
        chk("B_no_new_drop", int'(drop_count_out), 2);
        rdy = 1'b1;
        blank(8);
        chk("B_npops", dut_pops.size(), 5);
        chk("B0_y", pop_field(0, 1), 1);
        chk("B1_y", pop_field(1, 1), 2);
        chk("B2_y", pop_field(2, 1), 3);
        chk("B3_y", pop_field(3, 1), 4);
        chk("B4_y", pop_field(4, 1), 10);
        chk("B4_x", pop_field(4, 0), 100);

        // Frame C: disabled at frame start
        dut_pops.delete();
        enable_in = 1'b0;
        empty_line(0);
        one_evt(3, 333, 3);
        drive(0, 4, 0, 0, 0);
        drive(400, 4, 0, 0, 0);
        chk("idle_det_rst_mid", int'(det_rst_out), 1);
        blank(3);
        chk("C_npops", dut_pops.size(), 0);

        // Frame D: capture resumes
        enable_in = 1'b1;
        empty_line(0);
        one_evt(2, 222, 3);
        blank(3);
        chk("D_npops", dut_pops.size(), 1);
        chk("D0_x", pop_field(0, 0), 222);
        chk("D0_y", pop_field(0, 1), 2);

        // Frame E: reset mid-frame with entries queued
        dut_pops.delete();
        rdy = 1'b0;
        empty_line(0);
        for (int v = 1; v <= 3; v++) one_evt(v, 30 + v, v);
        chk("E_count3", int'(fifo_count_out), 3);
        drive(0, 20, 0, 0, 0);
        drive(1, 20, 0, 0, 0);
        rst_in = 1'b1;
        drive(500, 20, 0, 0, 0);
        rst_in = 1'b0;
        chk("E_rst_valid", int'(cand_valid_out), 0);
        chk("E_rst_count", int'(fifo_count_out), 0);
        chk("E_rst_drop", int'(drop_count_out), 0);
        drive(600, 20, 1, 50, 5);
        drive(1024, 20, 0, 0, 0);
        one_evt(21, 60, 6);
        chk("E_idle_count", int'(fifo_count_out), 0);
        blank(2);
        empty_line(0);
        one_evt(1, 77, 4);
        chk("E_resume_count", int'(fifo_count_out), 1);
        rdy = 1'b1;
        blank(3);
        chk("E_npops", dut_pops.size(), 1);
        chk("E0_x", pop_field(0, 0), 77);
        chk("E0_p", pop_field(0, 2), 4);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/marker_scan_ctrl.md
Name: marker_scan_ctrl

Overview:
Sequencer and result collector for one per-row stripe-flip marker detector in the marker_detect pipeline. It resets the detector at every line boundary and holds it in reset during blanking or when disabled. It keeps the best (lowest nt_probability) completed candidate in each active line and pushes it, tagged with the row number, into a small show-ahead FIFO. The FIFO drains over a valid/ready handshake to the downstream marker tracker.

Parameters:
H_ACTIVE, 1024, active pixels per line; hcount_in >= H_ACTIVE is blanking
V_ACTIVE, 768, active lines per frame; vcount_in >= V_ACTIVE is blanking
PROB_MAX, 50, largest det_prob_in accepted as a candidate
DEPTH, 4, candidate FIFO entries; power of 2, minimum 2

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  synchronous active-high reset
enable_in  input  1  scan enable; sampled only at frame start
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel row
det_done_in  input  1  detector done pulse
det_coord_in  input  11  detector centre column
det_prob_in  input  11  detector nt_probability
det_rst_out  output  1  drives detector reset
cand_valid_out  output  1  FIFO head valid
cand_ready_in  input  1  consumer accepts head
cand_x_out  output  11  head column
cand_y_out  output  10  head row
cand_prob_out  output  11  head nt_probability
fifo_count_out  output  3  occupancy, 0..DEPTH
drop_count_out  output  8  saturating count of lines lost to a full FIFO

Behaviour:
- Reset: all of the following happen on the clk_in edge where rst_in=1.
  - State goes to IDLE and the best-candidate register is cleared.
  - The FIFO is emptied: cand_valid_out=0, fifo_count_out=0. cand_x/y/prob_out=0.
  - drop_count_out=0 and det_rst_out=1.
  - Reset mid-frame discards everything. The block then waits for the next frame start.
- Frame start (fs) is the cycle with hcount_in==0 and vcount_in==0. Active is (hcount_in<H_ACTIVE) && (vcount_in<V_ACTIVE).
- States (2-bit register):
  - IDLE: on fs with enable_in=1, go to SCAN. Otherwise stay in IDLE.
  - SCAN: on fs with enable_in=0, go to IDLE. Otherwise stay in SCAN.
- det_rst_out is combinational: 1 when state==IDLE, or !active, or hcount_in==0. The detector therefore sees a fresh reset every line and is held in reset through blanking.
- Capture, in SCAN, active, det_done_in=1, det_prob_in<=PROB_MAX:
  - If best_valid=0, or det_prob_in < best_prob, load {det_coord_in, det_prob_in} and set best_valid=1.
  - A tie keeps the earlier candidate.
  - det_done_in with prob>PROB_MAX, in IDLE, or outside active is ignored.
- Line commit happens on the cycle with state==SCAN, hcount_in==H_ACTIVE and vcount_in<V_ACTIVE.
  - If best_valid=1, push {best_coord, vcount_in, best_prob}.
  - best_valid clears on that edge regardless of the push outcome.
  - A det_done_in on this cycle is outside active and is ignored.
- FIFO is show-ahead. Head outputs are valid the cycle after the push into an empty FIFO (1-cycle latency).
  - pop = cand_valid_out && cand_ready_in.
  - Push accepted when count<DEPTH, or when pop occurs in the same cycle (full + pop + push keeps count=DEPTH).
  - Push rejected when full without pop: entry dropped, drop_count_out increments and saturates at 255.
  - Empty + push + ready: no pop that cycle, since valid was 0.
  - Pointers wrap modulo DEPTH. fifo_count_out tracks exact occupancy.
- Head outputs hold stable while cand_valid_out=1 and cand_ready_in=0.
- Leaving SCAN (via IDLE) does not flush the FIFO. The consumer may continue draining.
- Arithmetic: all comparisons are unsigned 11-bit. No other arithmetic on data.

Test Plan:
- Enable=1, run frame; on line 5 pulse done at h=300 (coord 280, prob 12) and h=600 (coord 560, prob 7); ready=1 -> single entry x=560, y=5, prob=7; det_rst_out=1 at h=0 and h>=1024 of every line.
- Line 9: done coord 100 prob 60, then coord 400 prob 20, then coord 700 prob 20 -> entry x=400, y=9, prob=20 (60 rejected, tie keeps first).
- ready=0, candidates on lines 1..6 -> fifo_count_out reaches 4, lines 5 and 6 dropped, drop_count_out=2; then ready=1 -> pops in order y=1,2,3,4.
- FIFO full and ready=1 on the commit cycle of line 10 -> count stays 4, no drop, y=10 enters the tail.
- enable_in=0 at fs -> state IDLE, det_rst_out stays 1 for the whole frame, done pulses produce no entries; enable_in=1 at next fs resumes capture.
- rst_in=1 for one cycle at h=500 of line 20 with 3 entries queued -> cand_valid_out=0, fifo_count_out=0, drop_count_out=0; no entries until after the next fs.
